serv_lsu_ctrl: RTL and testbench

//  Sequencer for the bit-serial load/store memory interface: drives its shift-enable, init and byte-count

---
 rtl/serv_lsu_ctrl.sv | 103 ++++++++++
 tb/tb_serv_lsu_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serv_lsu_ctrl.sv
// serv_lsu_ctrl: sequences the bit-serial load/store interface: an init phase, then the Wishbone cycle, then the read phase
// Ports: i_clk/i_rst clock and async reset; i_start/i_we/i_misalign start an access; o_busy/o_done/o_trap/o_err status;
//        o_en/o_init/o_bytecnt drive the memory interface; o_wb_cyc/o_wb_we/i_wb_ack Wishbone; o_mem_ack gated ack
module serv_lsu_ctrl #(
  parameter bit          MISALIGN_TRAP = 1'b1,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_we,
  input  logic       i_misalign,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_trap,
  output logic       o_err,
  output logic       o_en,
  output logic       o_init,
  output logic [1:0] o_bytecnt,
  output logic       o_wb_cyc,
  output logic       o_wb_we,
  input  logic       i_wb_ack,
  output logic       o_mem_ack
);
  typedef enum logic [2:0] {IDLE, INIT, BUS, RD, DONE} state_e;
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        we_q, we_d, trap_q, trap_d, err_q, err_d;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      timer_q <= 16'd0;
      we_q    <= 1'b0;
      trap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      trap_q  <= trap_d;
      err_q   <= err_d;
    end
  end
  // cnt wraps 31->0 exactly on the INIT/RD exit, so RD always starts at 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    we_d    = we_q;
    trap_d  = trap_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = INIT;
        cnt_d   = 5'd0;
        we_d    = i_we;
      end
      INIT: begin
        cnt_d = cnt_q + 5'd1;
        if (&cnt_q) begin
          if (i_misalign && MISALIGN_TRAP) begin
            state_d = DONE;
            trap_d  = 1'b1;
          end else begin
            state_d = BUS;
            timer_d = 16'd0;
          end
        end
      end
      BUS: begin
        timer_d = timer_q + 16'd1;
        if (i_wb_ack) state_d = we_q ? DONE : RD;
        else if (timer_q == 16'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      RD: begin
        cnt_d = cnt_q + 5'd1;
        if (&cnt_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        trap_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign o_busy    = state_q != IDLE;
  assign o_done    = state_q == DONE;
  assign o_trap    = o_done & trap_q;
  assign o_err     = o_done & err_q;
  assign o_init    = state_q == INIT;
  assign o_en      = o_init | (state_q == RD);
  assign o_bytecnt = o_en ? cnt_q[4:3] : 2'd0;
  assign o_wb_cyc  = state_q == BUS;
  assign o_wb_we   = o_wb_cyc & we_q;
  assign o_mem_ack = i_wb_ack & o_wb_cyc;
endmodule

// File: tb/tb_serv_lsu_ctrl.sv
// tb_serv_lsu_ctrl: directed checks of the load/store sequencer with trap and no-trap instances
module tb_serv_lsu_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic i_start = 1'b0, i_we = 1'b0, i_misalign = 1'b0, i_wb_ack = 1'b0;
  logic o_busy, o_done, o_trap, o_err, o_en, o_init, o_wb_cyc, o_wb_we, o_mem_ack;
  logic [1:0] o_bytecnt;
  logic n_busy, n_done, n_trap, n_err, n_en, n_init, n_wb_cyc, n_wb_we, n_mem_ack;
  logic [1:0] n_bytecnt;
  int checks = 0, failures = 0, cyc0_n;
  always #5 clk = ~clk;
  serv_lsu_ctrl #(.MISALIGN_TRAP(1'b1), .TIMEOUT(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_we(i_we), .i_misalign(i_misalign),
    .o_busy(o_busy), .o_done(o_done), .o_trap(o_trap), .o_err(o_err), .o_en(o_en), .o_init(o_init),
    .o_bytecnt(o_bytecnt), .o_wb_cyc(o_wb_cyc), .o_wb_we(o_wb_we), .i_wb_ack(i_wb_ack), .o_mem_ack(o_mem_ack));
  serv_lsu_ctrl #(.MISALIGN_TRAP(1'b0), .TIMEOUT(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_we(i_we), .i_misalign(i_misalign),
    .o_busy(n_busy), .o_done(n_done), .o_trap(n_trap), .o_err(n_err), .o_en(n_en), .o_init(n_init),
    .o_bytecnt(n_bytecnt), .o_wb_cyc(n_wb_cyc), .o_wb_we(n_wb_we), .i_wb_ack(i_wb_ack), .o_mem_ack(n_mem_ack));
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_busy || n_busy) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_idle"}, int'(o_busy || n_busy), 0);
  endtask
  // one access from IDLE; cycle 1 is the cycle after the edge that samples i_start
  task automatic access(input string tag, input logic we, input logic mis, input logic hold, input int ack_at,
                        input int e_init, input int e_cyc, input int e_rd, input int e_done,
                        input int e_trap, input int e_err, input int e_mack);
    int init_n = 0, cyc_n = 0, rd_n = 0, mack_n = 0, done_c = 0, bad = 0, trap = 0, err = 0;
    cyc0_n = 0;
    i_we = we; i_misalign = mis; i_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) i_start = 1'b0;
    for (int c = 1; c <= 200 && done_c == 0; c++) begin
      if (o_wb_cyc) cyc_n++;
      i_wb_ack = o_wb_cyc && cyc_n == ack_at;
      #1;
      if (o_mem_ack) mack_n++;
      if (n_wb_cyc) cyc0_n++;
      if (o_init) init_n++;
      else if (o_en) rd_n++;
      if (o_bytecnt != (o_init ? 2'((init_n - 1) >> 3) : o_en ? 2'((rd_n - 1) >> 3) : 2'd0)) bad++;
      if (o_wb_cyc && o_wb_we != we) bad++;
      if (o_done) begin
        done_c = c; trap = int'(o_trap); err = int'(o_err);
      end else if (o_trap || o_err) bad++;
      @(posedge clk); #1;
    end
    i_wb_ack = 1'b0; i_misalign = 1'b0;
    check({tag, "_init_cycles"}, init_n, e_init);
    check({tag, "_cyc_cycles"}, cyc_n, e_cyc);
    check({tag, "_rd_cycles"}, rd_n, e_rd);
    check({tag, "_done_cycle"}, done_c, e_done);
    check({tag, "_trap"}, trap, e_trap);
    check({tag, "_err"}, err, e_err);
    check({tag, "_mem_ack"}, mack_n, e_mack);
    check({tag, "_bytecnt_we_bad"}, bad, 0);
    check({tag, "_after_done"}, int'({o_busy, o_done}), 0);
    if (hold) begin
      @(posedge clk); #1;
      check({tag, "_restart_init"}, int'(o_init), 1);
      i_start = 1'b0;
    end
  endtask
  initial begin
    #2;
    check("reset_outputs", int'({o_busy, o_done, o_trap, o_err, o_en, o_init, o_bytecnt, o_wb_cyc, o_wb_we, o_mem_ack}), 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    i_wb_ack = 1'b1; #1;
    check("idle_stray_ack", int'(o_mem_ack), 0);
    i_wb_ack = 1'b0;
    @(posedge clk); #1;
    access("store", 1'b1, 1'b0, 1'b0, 3, 32, 3, 0, 36, 0, 0, 1);
    wait_idle("store");
    access("load", 1'b0, 1'b0, 1'b0, 1, 32, 1, 32, 66, 0, 0, 1);
    wait_idle("load");
    access("trap", 1'b1, 1'b1, 1'b0, 0, 32, 0, 0, 33, 1, 0, 0);
    check("notrap_inst_bus", cyc0_n, 1);
    wait_idle("trap");
    access("timeout", 1'b1, 1'b0, 1'b0, 0, 32, 4, 0, 37, 0, 1, 0);
    wait_idle("timeout");
    access("ack_at_limit", 1'b1, 1'b0, 1'b0, 4, 32, 4, 0, 37, 0, 0, 1);
    wait_idle("ack_at_limit");
    access("load_late_ack", 1'b0, 1'b0, 1'b0, 4, 32, 4, 32, 69, 0, 0, 1);
    wait_idle("load_late_ack");
    // reset in BUS
    i_we = 1'b1; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (32) @(posedge clk);
    #1 check("rst_bus_pre", int'(o_wb_cyc), 1);
    #1 rst = 1'b1; i_wb_ack = 1'b1;
    #1 check("rst_bus_outputs", int'({o_busy, o_done, o_en, o_init, o_bytecnt, o_wb_cyc, o_wb_we, o_mem_ack}), 0);
    @(posedge clk); #1 check("rst_bus_no_done", int'(o_done), 0);
    #3 rst = 1'b0; i_wb_ack = 1'b0;
    @(posedge clk); #1;
    access("after_rst_bus", 1'b1, 1'b0, 1'b0, 1, 32, 1, 0, 34, 0, 0, 1);
    wait_idle("after_rst_bus");
    // reset in RD
    i_we = 1'b0; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (32) @(posedge clk);
    #1 i_wb_ack = 1'b1;
    @(posedge clk); #1 i_wb_ack = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("rst_rd_pre", int'({o_en, o_init, o_bytecnt}), 4'b1000);
    #1 rst = 1'b1;
    #1 check("rst_rd_outputs", int'({o_busy, o_done, o_en, o_init, o_bytecnt, o_wb_cyc, o_wb_we, o_mem_ack}), 0);
    @(posedge clk); #1 check("rst_rd_no_done", int'(o_done), 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    access("after_rst_rd", 1'b0, 1'b0, 1'b0, 2, 32, 2, 32, 67, 0, 0, 1);
    wait_idle("after_rst_rd");
    access("hold_start", 1'b1, 1'b0, 1'b1, 1, 32, 1, 0, 34, 0, 0, 1);
    wait_idle("hold_start");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
